// File: rtl/alu_issue.sv
// Command issue stage: buffers ALU commands in a small FIFO, hands the head
// to the ALU one at a time, and holds each returned result in a one-entry
// output slot. A wait counter abandons commands the ALU never answers.
module alu_issue #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [3:0]         s_cmd_i,
  input  logic [WIDTH-1:0]   s_a_i,
  input  logic [WIDTH-1:0]   s_b_i,
  output logic               alu_valid_o,
  output logic [3:0]         alu_cmd_o,
  output logic [WIDTH-1:0]   alu_a_o,
  output logic [WIDTH-1:0]   alu_b_o,
  input  logic               alu_ready_i,
  input  logic [WIDTH:0]     alu_x_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [WIDTH:0]     res_x_o,
  output logic [3:0]         res_cmd_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic               err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_mem_cmd [DEPTH];
  logic [WIDTH-1:0]   r_mem_a   [DEPTH];
  logic [WIDTH-1:0]   r_mem_b   [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic [TW-1:0]      r_wait;
  logic               r_res_valid;
  logic [WIDTH:0]     r_res_x;
  logic [3:0]         r_res_cmd;
  logic               r_err;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_drain;
  logic               w_slot_free;
  logic               w_capture;
  logic               w_drop;
  logic               w_start;

  // Ready depends only on registered occupancy, so a full FIFO never
  // accepts even if a pop happens in the same cycle.
  assign w_full      = (r_count == CW'(DEPTH));
  assign s_ready_o   = !w_full;
  assign w_push      = s_valid_i && !w_full;
  assign w_drain     = r_res_valid && res_ready_i;
  assign w_slot_free = !r_res_valid || w_drain;
  assign w_pop       = w_capture || w_drop;

  assign alu_valid_o = (r_state == BUSY);
  assign alu_cmd_o   = r_mem_cmd[r_rptr];
  assign alu_a_o     = r_mem_a[r_rptr];
  assign alu_b_o     = r_mem_b[r_rptr];
  assign res_valid_o = r_res_valid;
  assign res_x_o     = r_res_x;
  assign res_cmd_o   = r_res_cmd;
  assign count_o     = r_count;
  assign err_o       = r_err;

  // Issue FSM next state: leave IDLE only when a command is queued and the
  // result slot can take its answer; leave BUSY on response or timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_count != '0) && w_slot_free) begin
          w_state_nxt = BUSY;
          w_start     = 1'b1;
        end
      end
      BUSY: begin
        if (alu_ready_i) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_wait == TW'(TIMEOUT - 1)) begin
          w_drop      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_cmd[r_wptr] <= s_cmd_i;
      r_mem_a[r_wptr]   <= s_a_i;
      r_mem_b[r_wptr]   <= s_b_i;
    end
  end

  // FIFO pointers wrap naturally at DEPTH; occupancy nets push against pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Wait counter: restarts on each issue, counts cycles spent in BUSY.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait <= '0;
    end else if (w_start) begin
      r_wait <= '0;
    end else if (r_state == BUSY) begin
      r_wait <= r_wait + TW'(1);
    end
  end

  // Result slot: a capture wins over a simultaneous drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_valid <= 1'b0;
      r_res_x     <= '0;
      r_res_cmd   <= '0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_x     <= alu_x_i;
      r_res_cmd   <= alu_cmd_o;
    end else if (w_drain) begin
      r_res_valid <= 1'b0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_drop) begin
      r_err <= 1'b1;
    end
  end

endmodule
